// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch unit feeding the decode stage.
// Latency: request accepted in cycle N, response in N+1, out_valid in N+2.
// Backpressure: imem_req_ready low stalls in FETCH; out_ready low holds the instruction and blocks new requests.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/addr/ready        fetch request channel (word-aligned address)
//   imem_rsp_valid/data              fetch response strobe and instruction word
//   redirect_valid/pc                PC redirect from jalr execute (highest priority)
//   out_valid/ready, out_pc/instr    instruction handed to decode, plus decoded fields
//   out_opcode/funct3/funct7         slices of out_instr
//   fetch_count                      instructions consumed by decode (wraps)
//   fetch_fault                      misaligned redirect seen
// Build option: IFETCH_MISALIGN_CHECK_EN turns a misaligned redirect into a sticky
// FAULT state; without it the low two target bits are dropped.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        HOLD,
        DRAIN
`ifdef IFETCH_MISALIGN_CHECK_EN
        , FAULT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] out_pc_q, out_instr_q;
    logic        pend_q, pend_d;
    logic        capture;
    logic        accept;
    logic [31:0] tgt;

    // Fetch addresses are always word aligned; the low target bits only matter
    // for fault detection.
    assign tgt = {redirect_pc[31:2], 2'b00};

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misalign;
    assign misalign    = |redirect_pc[1:0];
    assign fetch_fault = fault_q;
`else
    logic unused_lsb;
    assign unused_lsb  = ^redirect_pc[1:0];
    assign fetch_fault = 1'b0;
`endif

    // No request is offered while reset is asserted, so nothing is accepted then.
    assign imem_req_valid = (state_q == FETCH) && !rst;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign out_valid   = (state_q == HOLD);
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;
    assign out_opcode  = out_instr_q[6:0];
    assign out_funct3  = out_instr_q[14:12];
    assign out_funct7  = out_instr_q[31:25];
    assign fetch_count = cnt_q;

    // pend tracks a request the memory still owes a response for, independent
    // of state, so a reset can tell whether a stale response is on its way.
    assign pend_d = accept || (pend_q && !imem_rsp_valid);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        fault_d = fault_q;
        if (redirect_valid && misalign) begin
            state_d = FAULT;
            fault_d = 1'b1;
        end else
`endif
        begin
            unique case (state_q)
                FETCH: begin
                    if (redirect_valid) begin
                        pc_d    = tgt;
                        // A request for the old pc that went out this cycle
                        // must be drained before fetching the new target.
                        state_d = accept ? DRAIN : FETCH;
                    end else if (accept) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_d    = tgt;
                        state_d = imem_rsp_valid ? FETCH : DRAIN;
                    end else if (imem_rsp_valid) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_d    = tgt;
                        state_d = FETCH;
                    end else if (out_ready) begin
                        pc_d    = pc_q + 32'd4;
                        cnt_d   = cnt_q + 32'd1;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    // A redirect here only retargets; the stale response is
                    // still drained so the FSM cannot wait forever.
                    if (redirect_valid) pc_d = tgt;
                    if (imem_rsp_valid) state_d = FETCH;
                end
`ifdef IFETCH_MISALIGN_CHECK_EN
                FAULT: state_d = FAULT;
`endif
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (pend_q && !imem_rsp_valid) ? DRAIN : FETCH;
            pend_q      <= pend_d;
            pc_q        <= RESET_PC;
            cnt_q       <= 32'd0;
            out_pc_q    <= 32'd0;
            out_instr_q <= 32'd0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                out_pc_q    <= pc_q;
                out_instr_q <= imem_rsp_data;
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

endmodule
